// File: rtl/fpu_lzd_pkg.sv
// Shared types and constants for the FPU leading-zero-detect arbiter.
package fpu_lzd_pkg;

  localparam int unsigned LZD_MAN_W = 24;
  localparam int unsigned LZD_CNT_W = 5;
  localparam int unsigned LZD_TAG_W = 4;

  localparam logic SRC_FMADD = 1'b0;
  localparam logic SRC_FADD  = 1'b1;

  typedef struct packed {
    logic [LZD_CNT_W-1:0] lzc;
    logic                 zero;
    logic                 src;
    logic [LZD_TAG_W-1:0] tag;
  } lzd_result_t;

  // 2-bit LZD cell: {any bit set, leading zero count within the pair}
  function automatic logic [1:0] lzd2_cell(input logic [1:0] bits);
    return {bits[1] | bits[0], ~bits[1]};
  endfunction

endpackage

// File: rtl/fpu_lzd_count.sv
// Combinational leading-zero counter: 2-bit LZD cells feeding a binary merge tree.
module fpu_lzd_count
  import fpu_lzd_pkg::*;
#(
  parameter int unsigned MAN_W = LZD_MAN_W,
  parameter int unsigned CNT_W = LZD_CNT_W
) (
  input  logic [MAN_W-1:0] i_man,
  output logic [CNT_W-1:0] o_lzc,
  output logic             o_zero
);

  localparam int unsigned LVLS  = $clog2(MAN_W);
  localparam int unsigned PAD_W = 1 << LVLS;
  localparam int unsigned CELLS = PAD_W / 2;

  // Left-justify into a power-of-two width; the zero padding sits below the LSB
  logic [PAD_W-1:0] w_pad;
  assign w_pad = PAD_W'(i_man) << (PAD_W - MAN_W);

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int unsigned NODES = CELLS >> l;
    logic            w_vld [NODES];
    logic [LVLS-1:0] w_cnt [NODES];

    for (genvar j = 0; j < NODES; j++) begin : g_node
      if (l == 0) begin : g_leaf
        logic [1:0] w_cell;
        assign w_cell   = lzd2_cell(w_pad[PAD_W-1-2*j -: 2]);
        assign w_vld[j] = w_cell[1];
        assign w_cnt[j] = LVLS'(w_cell[0]);
      end else begin : g_merge
        // An empty upper half adds its full width to the lower half's count
        assign w_vld[j] = g_lvl[l-1].w_vld[2*j] | g_lvl[l-1].w_vld[2*j+1];
        assign w_cnt[j] = g_lvl[l-1].w_vld[2*j] ? g_lvl[l-1].w_cnt[2*j]
                        : ((LVLS'(1) << l) | g_lvl[l-1].w_cnt[2*j+1]);
      end
    end
  end

  assign o_zero = ~g_lvl[LVLS-1].w_vld[0];
  assign o_lzc  = o_zero ? CNT_W'(MAN_W) : CNT_W'(g_lvl[LVLS-1].w_cnt[0]);

endmodule

// File: rtl/fpu_lzd_arbiter.sv
// Round-robin shared two-stage LZ counter for the FMADD and FADD/convert normalisers.
module fpu_lzd_arbiter
  import fpu_lzd_pkg::*;
#(
  parameter int unsigned MAN_W = LZD_MAN_W,
  parameter int unsigned CNT_W = LZD_CNT_W,
  parameter int unsigned TAG_W = LZD_TAG_W
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [MAN_W-1:0] req0_man_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [MAN_W-1:0] req1_man_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] out_lzc_o,
  output logic             out_zero_o,
  output logic             out_src_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic             r_last_grant;
  logic             r_s1_valid;
  logic [MAN_W-1:0] r_s1_man;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_src;
  logic             r_s2_valid;
  lzd_result_t      r_s2;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_win1;
  logic             w_accept;
  logic [CNT_W-1:0] w_lzc;
  logic             w_zero;

  assign w_s2_adv = ~r_s2_valid | out_ready_i;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;

  // Requester 1 wins when alone, or under contention when requester 0 went last
  assign w_win1   = req1_valid_i & (~req0_valid_i | (r_last_grant == SRC_FMADD));
  assign w_accept = w_s1_adv & (req0_valid_i | req1_valid_i);

  assign req0_ready_o = rst_l & w_s1_adv & req0_valid_i & ~w_win1;
  assign req1_ready_o = rst_l & w_s1_adv & w_win1;

  // Stage 1: capture the winning operand
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_last_grant <= SRC_FADD;
      r_s1_valid   <= 1'b0;
      r_s1_man     <= '0;
      r_s1_tag     <= '0;
      r_s1_src     <= SRC_FMADD;
    end else if (w_accept) begin
      r_last_grant <= w_win1 ? SRC_FADD : SRC_FMADD;
      r_s1_valid   <= 1'b1;
      r_s1_man     <= w_win1 ? req1_man_i : req0_man_i;
      r_s1_tag     <= w_win1 ? req1_tag_i : req0_tag_i;
      r_s1_src     <= w_win1 ? SRC_FADD : SRC_FMADD;
    end else if (w_s1_adv) begin
      r_s1_valid   <= 1'b0;
    end
  end

  fpu_lzd_count #(
    .MAN_W (MAN_W),
    .CNT_W (CNT_W)
  ) u_count (
    .i_man  (r_s1_man),
    .o_lzc  (w_lzc),
    .o_zero (w_zero)
  );

  // Stage 2: register the count; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_s1_adv && r_s1_valid) begin
      r_s2_valid <= 1'b1;
      r_s2.lzc   <= LZD_CNT_W'(w_lzc);
      r_s2.zero  <= w_zero;
      r_s2.src   <= r_s1_src;
      r_s2.tag   <= LZD_TAG_W'(r_s1_tag);
    end else if (w_s2_adv) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_s2_valid;
  assign out_lzc_o   = CNT_W'(r_s2.lzc);
  assign out_zero_o  = r_s2.zero;
  assign out_src_o   = r_s2.src;
  assign out_tag_o   = TAG_W'(r_s2.tag);

endmodule

// File: tb/tb_fpu_lzd_arbiter.sv
// Bench for fpu_lzd_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fpu_lzd_arbiter;

  localparam int unsigned MAN_W = 24;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rst_l;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [MAN_W-1:0] req0_man, req1_man;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             out_valid, out_ready;
  logic [CNT_W-1:0] out_lzc;
  logic             out_zero, out_src;
  logic [TAG_W-1:0] out_tag;

  fpu_lzd_arbiter dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_man_i   (req0_man),
    .req0_tag_i   (req0_tag),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_man_i   (req1_man),
    .req1_tag_i   (req1_tag),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_lzc_o    (out_lzc),
    .out_zero_o   (out_zero),
    .out_src_o    (out_src),
    .out_tag_o    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MAN_W-1:0] man;
    logic [TAG_W-1:0] tag;
    logic             src;
    bit               aged;
  } item_t;

  item_t q[$];
  bit    m_last;
  int    n_total = 0;
  int    n_pass  = 0;

  function automatic int ref_lzc(input logic [MAN_W-1:0] m);
    for (int i = MAN_W - 1; i >= 0; i--) if (m[i]) return MAN_W - 1 - i;
    return MAN_W;
  endfunction

  function automatic logic [MAN_W-1:0] rand_man();
    int unsigned sel = $urandom_range(0, 9);
    logic [31:0] r   = $urandom;
    logic [MAN_W-1:0] m = r[MAN_W-1:0];
    if (sel == 0) return '0;
    if (sel == 1) return m | 24'h800000;
    return m >> $urandom_range(0, 23);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock of traffic: predict readies/outputs, compare, then advance the model over the edge.
  task automatic cycle(input string tag, output bit acc, output bit win);
    bit adv, ev;
    item_t it;
    #1;
    adv = !(q.size() == 2 && !out_ready);
    win = (req0_valid && req1_valid) ? !m_last : req1_valid;
    acc = adv && (req0_valid || req1_valid);
    check($sformatf("%s_rdy0", tag), 32'(req0_ready), 32'(acc && !win));
    check($sformatf("%s_rdy1", tag), 32'(req1_ready), 32'(acc && win));
    ev = (q.size() > 0) && q[0].aged;
    check($sformatf("%s_ovld", tag), 32'(out_valid), 32'(ev));
    if (ev) begin
      check($sformatf("%s_lzc", tag),  32'(out_lzc),  32'(ref_lzc(q[0].man)));
      check($sformatf("%s_zero", tag), 32'(out_zero), 32'(q[0].man == '0));
      check($sformatf("%s_src", tag),  32'(out_src),  32'(q[0].src));
      check($sformatf("%s_tag", tag),  32'(out_tag),  32'(q[0].tag));
    end
    @(posedge clk);
    if (ev && out_ready) void'(q.pop_front());
    foreach (q[i]) q[i].aged = 1'b1;
    if (acc) begin
      it.man  = win ? req1_man : req0_man;
      it.tag  = win ? req1_tag : req0_tag;
      it.src  = win;
      it.aged = 1'b0;
      q.push_back(it);
      m_last = win;
    end
    #1;
  endtask

  task automatic refill(input bit win);
    if (win) begin
      req1_man = rand_man();
      req1_tag = 4'($urandom);
    end else begin
      req0_man = rand_man();
      req0_tag = 4'($urandom);
    end
  endtask

  task automatic drain(input string tag);
    bit a, w;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) cycle(tag, a, w);
    check($sformatf("%s_empty", tag), 32'(out_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc, win;

    // Reset state, including ready gating while rst_l is low
    rst_l = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req0_man = 24'h800000; req0_tag = 4'd3;
    req1_valid = 1'b0; req1_man = '0;         req1_tag = '0;
    #12;
    check("rst_rdy0", 32'(req0_ready), 32'(0));
    check("rst_ovld", 32'(out_valid), 32'(0));
    check("rst_lzc",  32'(out_lzc),   32'(0));
    check("rst_zero", 32'(out_zero),  32'(0));
    check("rst_src",  32'(out_src),   32'(0));
    check("rst_tag",  32'(out_tag),   32'(0));
    req0_valid = 1'b0;
    #10 rst_l = 1'b1;
    m_last = 1'b1;
    @(posedge clk); #1;

    // Lone req0 with the top bit set
    req0_valid = 1'b1; req0_man = 24'h800000; req0_tag = 4'd3;
    cycle("t1a", acc, win);
    req0_valid = 1'b0;
    cycle("t1b", acc, win);
    check("t1_ovld", 32'(out_valid), 32'(1));
    check("t1_lzc",  32'(out_lzc),   32'(0));
    check("t1_zero", 32'(out_zero),  32'(0));
    check("t1_src",  32'(out_src),   32'(0));
    check("t1_tag",  32'(out_tag),   32'(3));

    // req1 back-to-back: LSB-only then all-zero
    req1_valid = 1'b1; req1_man = 24'h000001; req1_tag = 4'd5;
    cycle("t2a", acc, win);
    req1_man = 24'h000000; req1_tag = 4'd6;
    cycle("t2b", acc, win);
    req1_valid = 1'b0;
    check("t2_lzc_a",  32'(out_lzc),  32'(23));
    check("t2_zero_a", 32'(out_zero), 32'(0));
    check("t2_src_a",  32'(out_src),  32'(1));
    cycle("t2c", acc, win);
    check("t2_ovld_b", 32'(out_valid), 32'(1));
    check("t2_lzc_b",  32'(out_lzc),   32'(24));
    check("t2_zero_b", 32'(out_zero),  32'(1));
    check("t2_tag_b",  32'(out_tag),   32'(6));
    drain("t2d");

    // Contention: strict alternation starting with req0
    req0_valid = 1'b1; req0_man = 24'h0F0000; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_man = 24'h000300; req1_tag = 4'd8;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_grant1", 32'(req1_ready), 32'(i % 2));
      cycle("t3", acc, win);
      if (acc && !win) begin req0_man = 24'h000800; req0_tag = 4'd2; end
      if (acc && win)  begin req1_man = 24'h000001; req1_tag = 4'd9; end
    end
    drain("t3d");

    // Backpressure: two accepts, then both readies low until out_ready returns
    out_ready = 1'b0;
    req0_valid = 1'b1; refill(1'b0);
    req1_valid = 1'b1; refill(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        #1;
        check("t4_stall_r0", 32'(req0_ready), 32'(0));
        check("t4_stall_r1", 32'(req1_ready), 32'(0));
      end
      cycle("t4s", acc, win);
      if (acc) refill(win);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle("t4r", acc, win);
      if (acc) refill(win);
    end
    drain("t4d");

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    req0_valid = 1'b1; refill(1'b0);
    req1_valid = 1'b1; refill(1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle("t5f", acc, win);
      if (acc) refill(win);
    end
    #2 rst_l = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("t5_rst_ovld", 32'(out_valid), 32'(0));
    check("t5_rst_tag",  32'(out_tag),   32'(0));
    q.delete();
    m_last = 1'b1;
    #3 rst_l = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_man = 24'h004000; req0_tag = 4'd7;
    req1_valid = 1'b1; req1_man = 24'h000010; req1_tag = 4'd12;
    #1;
    check("t5_first_r0", 32'(req0_ready), 32'(1));
    cycle("t5a", acc, win);
    req0_valid = 1'b0;
    cycle("t5b", acc, win);
    req1_valid = 1'b0;
    check("t5_lzc", 32'(out_lzc), 32'(9));
    check("t5_src", 32'(out_src), 32'(0));
    check("t5_tag", 32'(out_tag), 32'(7));
    drain("t5d");

    // Random traffic with random backpressure; valids held until accepted
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd", acc, win);
      if (acc) begin
        if (win) req1_valid = ($urandom_range(0, 9) < 7);
        else     req0_valid = ($urandom_range(0, 9) < 7);
        refill(win);
      end
      if (!req0_valid && $urandom_range(0, 1) == 1) begin req0_valid = 1'b1; refill(1'b0); end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin req1_valid = 1'b1; refill(1'b1); end
    end
    drain("rndd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
